// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receive path: character FSM encoding,
// framing constants and status-byte bit positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int unsigned PS2_DATA_BITS = 8;
    localparam int unsigned PS2_PKT_BYTES = 3;

    // Bit positions inside packet byte 0 (status)
    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XSIGN = 4;
    localparam int unsigned YSIGN = 5;
    localparam int unsigned XOVF  = 6;
    localparam int unsigned YOVF  = 7;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(logic [PS2_DATA_BITS-1:0] data, logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_char_rx.sv
// PS/2 character receiver: start bit, 8 data bits LSB-first, odd parity, stop.
// Advances one bit per falling edge of Mouse_Clk. char_done/char_ok/char_byte are
// presented combinationally during the STOP bit so the consumer can act on that
// same edge. Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_char_rx
    import ps2_pkg::*;
(
    input  logic       Mouse_Clk,
    input  logic       reset,
    input  logic       Mouse_Data,
    output logic       char_done,
    output logic       char_ok,
    output logic [7:0] char_byte,
    output logic       char_busy
);

    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       parity_ok;

    // Bit-level state register, advanced on the falling PS/2 clock edge
    always_ff @(negedge Mouse_Clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    // Next-state logic: framing of one character
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        unique case (state_q)
            IDLE: begin
                // A high line while idle is a glitch or idle level, not an error
                if (!Mouse_Data) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shift_d   = {Mouse_Data, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                par_d   = Mouse_Data;
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign parity_ok = odd_parity_ok(shift_q, par_q);

    // Character result is valid during the STOP bit, judged on the live stop level
    always_comb begin
        char_done = (state_q == STOP);
        char_byte = shift_q;
`ifdef PS2_PARITY_CHECK_EN
        char_ok   = Mouse_Data & parity_ok;
`else
        char_ok   = Mouse_Data;
`endif
    end

`ifndef PS2_PARITY_CHECK_EN
    // Parity is still captured but deliberately ignored in this build
    logic unused_parity_ok;
    assign unused_parity_ok = parity_ok;
`endif

    assign char_busy = (state_q != IDLE);

endmodule

// File: rtl/ps2_mouse_packet_ctrl.sv
// PS/2 mouse packet sequencer. Assembles three validated characters into a
// movement packet, applies sync-bit and overflow rules, and publishes the result
// with a toggle strobe for safe transfer into another clock domain.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity failures become rejects).
module ps2_mouse_packet_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned ERR_CNT_W        = 8,
    parameter bit          REQUIRE_SYNC_BIT = 1'b1
) (
    input  logic                 Mouse_Clk,
    input  logic                 reset,
    input  logic                 Mouse_Data,
    output logic [7:0]           pkt_status,
    output logic [8:0]           pkt_dx,
    output logic [8:0]           pkt_dy,
    output logic                 pkt_toggle,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    logic       char_done;
    logic       char_ok;
    logic [7:0] char_byte;
    logic       char_busy;

    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           byte0_q, byte0_d;
    logic [7:0]           byte1_q, byte1_d;
    logic [7:0]           status_q, status_d;
    logic [8:0]           dx_q, dx_d;
    logic [8:0]           dy_q, dy_d;
    logic                 toggle_q, toggle_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic reject;
    logic commit;

    ps2_char_rx u_char_rx (
        .Mouse_Clk  (Mouse_Clk),
        .reset      (reset),
        .Mouse_Data (Mouse_Data),
        .char_done  (char_done),
        .char_ok    (char_ok),
        .char_byte  (char_byte),
        .char_busy  (char_busy)
    );

    // Classify a finished character as rejected or committed
    always_comb begin
        reject = 1'b0;
        commit = 1'b0;
        if (char_done) begin
            if (!char_ok) begin
                reject = 1'b1;
            end else if (REQUIRE_SYNC_BIT && (byte_idx_q == 2'd0) && !char_byte[SYNC]) begin
                // Misaligned stream: drop this byte and keep hunting for byte 0
                reject = 1'b1;
            end else begin
                commit = 1'b1;
            end
        end
    end

    // Packet assembly, accept and error accounting
    always_comb begin
        byte_idx_d  = byte_idx_q;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;
        status_d    = status_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        toggle_d    = toggle_q;
        frame_err_d = reject;
        err_cnt_d   = err_cnt_q;

        if (reject) begin
            byte_idx_d = 2'd0;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (commit) begin
            unique case (byte_idx_q)
                2'd0: begin
                    byte0_d    = char_byte;
                    byte_idx_d = 2'd1;
                end
                2'd1: begin
                    byte1_d    = char_byte;
                    byte_idx_d = 2'd2;
                end
                2'd2: begin
                    status_d   = byte0_q;
                    dx_d       = byte0_q[XOVF] ? 9'd0 : {byte0_q[XSIGN], byte1_q};
                    dy_d       = byte0_q[YOVF] ? 9'd0 : {byte0_q[YSIGN], char_byte};
                    toggle_d   = ~toggle_q;
                    byte_idx_d = 2'(PS2_PKT_BYTES) - 2'd3;
                end
                default: byte_idx_d = 2'd0;
            endcase
        end
    end

    // Packet-level state register on the falling PS/2 clock edge
    always_ff @(negedge Mouse_Clk or posedge reset) begin
        if (reset) begin
            byte_idx_q  <= 2'd0;
            byte0_q     <= '0;
            byte1_q     <= '0;
            status_q    <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            toggle_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            status_q    <= status_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            toggle_q    <= toggle_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        pkt_status = status_q;
        pkt_dx     = dx_q;
        pkt_dy     = dy_q;
        pkt_toggle = toggle_q;
        frame_err  = frame_err_q;
        err_count  = err_cnt_q;
        busy       = char_busy | (byte_idx_q != 2'd0);
    end

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Directed self-checking bench for ps2_mouse_packet_ctrl. Data is driven just
// after the rising edge and outputs are sampled 1 time unit after the rising
// edge, well away from the falling edge the DUT acts on.
// Honours PS2_PARITY_CHECK_EN for the parity scenario.
module tb_ps2_mouse_packet_ctrl;

    logic       Mouse_Clk;
    logic       reset;
    logic       Mouse_Data;
    logic [7:0] pkt_status;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic       pkt_toggle;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    int checks;
    int errors;
    logic exp_tog;

    ps2_mouse_packet_ctrl #(
        .ERR_CNT_W        (8),
        .REQUIRE_SYNC_BIT (1'b1)
    ) dut (
        .Mouse_Clk  (Mouse_Clk),
        .reset      (reset),
        .Mouse_Data (Mouse_Data),
        .pkt_status (pkt_status),
        .pkt_dx     (pkt_dx),
        .pkt_dy     (pkt_dy),
        .pkt_toggle (pkt_toggle),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial begin
        Mouse_Clk = 1'b1;
        forever #10 Mouse_Clk = ~Mouse_Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // Drive the first nbits of an 11-bit frame; a full frame returns the line to idle
    task automatic send_frame(input logic [7:0] b, input logic flip_par,
                              input logic stop_bit, input int nbits);
        logic [10:0] f;
        f = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge Mouse_Clk);
            Mouse_Data = f[i];
        end
        @(posedge Mouse_Clk);
        if (nbits == 11) Mouse_Data = 1'b1;
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 1'b1, 11);
        send_frame(b1, 1'b0, 1'b1, 11);
        send_frame(b2, 1'b0, 1'b1, 11);
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        Mouse_Data = 1'b1;
        repeat (3) @(posedge Mouse_Clk);
        #1;
        checks++;
        if ({pkt_status, pkt_dx, pkt_dy, pkt_toggle, frame_err, err_count, busy} !== '0) begin
            $display("FAIL reset_outputs: actual=%h required=0",
                     {pkt_status, pkt_dx, pkt_dy, pkt_toggle, frame_err, err_count, busy});
            errors++;
        end
        reset = 1'b0;
        exp_tog = 1'b0;
        repeat (2) @(posedge Mouse_Clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_busy: actual=%b required=0", busy);
            errors++;
        end
    endtask

    task automatic test_basic;
        send_frame(8'h08, 1'b0, 1'b1, 11);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy_mid: actual=%b required=1", busy);
            errors++;
        end
        send_frame(8'h05, 1'b0, 1'b1, 11);
        send_frame(8'h03, 1'b0, 1'b1, 11);
        exp_tog = ~exp_tog;
        checks++;
        if (pkt_status !== 8'h08) begin
            $display("FAIL basic_status: actual=%h required=08", pkt_status); errors++;
        end
        checks++;
        if (pkt_dx !== 9'h005) begin
            $display("FAIL basic_dx: actual=%h required=005", pkt_dx); errors++;
        end
        checks++;
        if (pkt_dy !== 9'h003) begin
            $display("FAIL basic_dy: actual=%h required=003", pkt_dy); errors++;
        end
        checks++;
        if (pkt_toggle !== exp_tog) begin
            $display("FAIL basic_toggle: actual=%b required=%b", pkt_toggle, exp_tog); errors++;
        end
        checks++;
        if (err_count !== 8'd0) begin
            $display("FAIL basic_errcnt: actual=%0d required=0", err_count); errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL basic_busy_end: actual=%b required=0", busy); errors++;
        end
    endtask

    task automatic test_negative;
        send_pkt(8'h38, 8'hFB, 8'hFE);
        exp_tog = ~exp_tog;
        checks++;
        if (pkt_status !== 8'h38) begin
            $display("FAIL neg_status: actual=%h required=38", pkt_status); errors++;
        end
        checks++;
        if (pkt_dx !== 9'h1FB) begin
            $display("FAIL neg_dx: actual=%h required=1fb", pkt_dx); errors++;
        end
        checks++;
        if (pkt_dy !== 9'h1FE) begin
            $display("FAIL neg_dy: actual=%h required=1fe", pkt_dy); errors++;
        end
        checks++;
        if (pkt_toggle !== exp_tog) begin
            $display("FAIL neg_toggle: actual=%b required=%b", pkt_toggle, exp_tog); errors++;
        end
    endtask

    task automatic test_overflow;
        send_pkt(8'h48, 8'h7F, 8'h01);
        exp_tog = ~exp_tog;
        checks++;
        if (pkt_status !== 8'h48) begin
            $display("FAIL ovf_status: actual=%h required=48", pkt_status); errors++;
        end
        checks++;
        if (pkt_dx !== 9'h000) begin
            $display("FAIL ovf_dx: actual=%h required=000", pkt_dx); errors++;
        end
        checks++;
        if (pkt_dy !== 9'h001) begin
            $display("FAIL ovf_dy: actual=%h required=001", pkt_dy); errors++;
        end
        checks++;
        if (pkt_toggle !== exp_tog) begin
            $display("FAIL ovf_toggle: actual=%b required=%b", pkt_toggle, exp_tog); errors++;
        end
    endtask

    task automatic test_stop_err;
        send_frame(8'h08, 1'b0, 1'b1, 11);
        send_frame(8'h05, 1'b0, 1'b0, 11);
        checks++;
        if (frame_err !== 1'b1) begin
            $display("FAIL stop_frame_err: actual=%b required=1", frame_err); errors++;
        end
        checks++;
        if (err_count !== 8'd1) begin
            $display("FAIL stop_errcnt: actual=%0d required=1", err_count); errors++;
        end
        checks++;
        if ({pkt_status, pkt_dx, pkt_dy, pkt_toggle} !== {8'h48, 9'h000, 9'h001, exp_tog}) begin
            $display("FAIL stop_outputs_held: actual=%h/%h/%h/%b required=48/000/001/%b",
                     pkt_status, pkt_dx, pkt_dy, pkt_toggle, exp_tog);
            errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL stop_busy: actual=%b required=0", busy); errors++;
        end
        @(posedge Mouse_Clk);
        #1;
        checks++;
        if (frame_err !== 1'b0) begin
            $display("FAIL stop_frame_err_pulse: actual=%b required=0", frame_err); errors++;
        end
        send_pkt(8'h08, 8'h02, 8'h02);
        exp_tog = ~exp_tog;
        checks++;
        if ({pkt_dx, pkt_dy, pkt_toggle} !== {9'h002, 9'h002, exp_tog}) begin
            $display("FAIL stop_recover: actual=%h/%h/%b required=002/002/%b",
                     pkt_dx, pkt_dy, pkt_toggle, exp_tog);
            errors++;
        end
    endtask

    task automatic test_sync;
        send_frame(8'h00, 1'b0, 1'b1, 11);
        checks++;
        if (frame_err !== 1'b1 || err_count !== 8'd2) begin
            $display("FAIL sync_reject: actual=%b/%0d required=1/2", frame_err, err_count);
            errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL sync_busy: actual=%b required=0", busy); errors++;
        end
        send_pkt(8'h08, 8'h01, 8'h01);
        exp_tog = ~exp_tog;
        checks++;
        if ({pkt_status, pkt_dx, pkt_dy, pkt_toggle} !== {8'h08, 9'h001, 9'h001, exp_tog}) begin
            $display("FAIL sync_accept: actual=%h/%h/%h/%b required=08/001/001/%b",
                     pkt_status, pkt_dx, pkt_dy, pkt_toggle, exp_tog);
            errors++;
        end
    endtask

    task automatic test_parity;
        send_frame(8'h08, 1'b0, 1'b1, 11);
        send_frame(8'h04, 1'b0, 1'b1, 11);
        send_frame(8'h06, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
        checks++;
        if (frame_err !== 1'b1 || err_count !== 8'd3) begin
            $display("FAIL parity_reject: actual=%b/%0d required=1/3", frame_err, err_count);
            errors++;
        end
        checks++;
        if ({pkt_dx, pkt_dy, pkt_toggle} !== {9'h001, 9'h001, exp_tog}) begin
            $display("FAIL parity_held: actual=%h/%h/%b required=001/001/%b",
                     pkt_dx, pkt_dy, pkt_toggle, exp_tog);
            errors++;
        end
`else
        exp_tog = ~exp_tog;
        checks++;
        if (frame_err !== 1'b0 || err_count !== 8'd2) begin
            $display("FAIL parity_ignored: actual=%b/%0d required=0/2", frame_err, err_count);
            errors++;
        end
        checks++;
        if ({pkt_dx, pkt_dy, pkt_toggle} !== {9'h004, 9'h006, exp_tog}) begin
            $display("FAIL parity_accept: actual=%h/%h/%b required=004/006/%b",
                     pkt_dx, pkt_dy, pkt_toggle, exp_tog);
            errors++;
        end
`endif
    endtask

    task automatic test_reset_mid;
        // 11 edges of byte 0 plus 9 edges of byte 1 = 20 edges into the packet
        send_frame(8'h08, 1'b0, 1'b1, 11);
        send_frame(8'h09, 1'b0, 1'b1, 9);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_busy_before: actual=%b required=1", busy); errors++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pkt_status, pkt_dx, pkt_dy, pkt_toggle, frame_err, err_count, busy} !== '0) begin
            $display("FAIL mid_reset_outputs: actual=%h required=0",
                     {pkt_status, pkt_dx, pkt_dy, pkt_toggle, frame_err, err_count, busy});
            errors++;
        end
        Mouse_Data = 1'b1;
        @(posedge Mouse_Clk);
        #1;
        reset   = 1'b0;
        exp_tog = 1'b0;
        send_pkt(8'h08, 8'h07, 8'h05);
        exp_tog = ~exp_tog;
        checks++;
        if ({pkt_status, pkt_dx, pkt_dy, pkt_toggle, err_count} !==
            {8'h08, 9'h007, 9'h005, exp_tog, 8'd0}) begin
            $display("FAIL mid_recover: actual=%h/%h/%h/%b/%0d required=08/007/005/%b/0",
                     pkt_status, pkt_dx, pkt_dy, pkt_toggle, err_count, exp_tog);
            errors++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_tog    = 1'b0;
        reset      = 1'b1;
        Mouse_Data = 1'b1;
        test_reset;
        test_basic;
        test_negative;
        test_overflow;
        test_stop_err;
        test_sync;
        test_parity;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
